// File: rtl/phase_unwrap_tracker.sv
// phase_unwrap_tracker: rebuilds a continuous phase from a wrapped signed
// phase stream by tracking wrap events in a signed winding counter.
module phase_unwrap_tracker #(
  parameter int DATA_W   = 14,
  parameter int WIND_W   = 8,
  parameter int JUMP_THR = 8192
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     valid_i,
  input  logic                     clear_i,
  output logic [DATA_W+WIND_W-1:0] data_o,
  output logic                     valid_o,
  output logic [WIND_W-1:0]        winding_o,
  output logic                     wrap_up_o,
  output logic                     wrap_dn_o,
  output logic                     sat_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_TRACK = 2'd1,
    S_SAT   = 2'd2
  } state_t;

  localparam logic signed [DATA_W:0] L_THR  = (DATA_W+1)'(JUMP_THR);
  localparam logic [WIND_W-1:0]      L_WMAX = {1'b0, {(WIND_W-1){1'b1}}};
  localparam logic [WIND_W-1:0]      L_WMIN = {1'b1, {(WIND_W-1){1'b0}}};

  state_t                     r_state;
  state_t                     w_state_nx;
  state_t                     w_base_state;
  logic [WIND_W-1:0]          r_wind;
  logic [WIND_W-1:0]          w_wind_nx;
  logic [WIND_W-1:0]          w_base_wind;
  logic [DATA_W-1:0]          r_prev;
  logic [DATA_W+WIND_W-1:0]   r_data;
  logic [DATA_W+WIND_W-1:0]   w_data_nx;
  logic                       r_valid;
  logic                       r_up;
  logic                       r_dn;
  logic                       w_up;
  logic                       w_dn;
  logic signed [DATA_W:0]     w_diff;
  logic                       w_jump_up;
  logic                       w_jump_dn;

  // Sample-to-sample jump at one extra bit so it can never overflow.
  always_comb begin
    w_diff    = $signed({data_i[DATA_W-1], data_i}) - $signed({r_prev[DATA_W-1], r_prev});
    w_jump_up = (w_diff < -L_THR);
    w_jump_dn = (w_diff >= L_THR);
  end

  // Next-state, winding update and wrap pulses; clear_i rewinds to EMPTY
  // first so a sample arriving with it is treated as the first sample.
  always_comb begin
    w_base_state = clear_i ? S_EMPTY : r_state;
    w_base_wind  = clear_i ? '0 : r_wind;
    w_state_nx   = w_base_state;
    w_wind_nx    = w_base_wind;
    w_up         = 1'b0;
    w_dn         = 1'b0;
    if (valid_i) begin
      case (w_base_state)
        S_EMPTY: w_state_nx = S_TRACK;
        S_TRACK: begin
          if (w_jump_up) begin
            w_up = 1'b1;
            if (w_base_wind == L_WMAX) w_state_nx = S_SAT;
            else                       w_wind_nx  = w_base_wind + 1'b1;
          end else if (w_jump_dn) begin
            w_dn = 1'b1;
            if (w_base_wind == L_WMIN) w_state_nx = S_SAT;
            else                       w_wind_nx  = w_base_wind - 1'b1;
          end
        end
        S_SAT: begin
          w_up = w_jump_up;
          w_dn = w_jump_dn && !w_jump_up;
        end
        default: w_state_nx = S_EMPTY;
      endcase
    end
    w_data_nx = {w_wind_nx, {DATA_W{1'b0}}} + {{WIND_W{data_i[DATA_W-1]}}, data_i};
  end

  // State, history and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_wind  <= '0;
      r_prev  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wind  <= w_wind_nx;
      r_valid <= valid_i;
      r_up    <= w_up;
      r_dn    <= w_dn;
      if (valid_i) begin
        r_prev <= data_i;
        r_data <= w_data_nx;
      end else if (clear_i) begin
        r_prev <= '0;
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign winding_o = r_wind;
  assign wrap_up_o = r_up;
  assign wrap_dn_o = r_dn;
  assign sat_o     = (r_state == S_SAT);

endmodule

// File: tb/tb_phase_unwrap_tracker.sv
// Directed self-checking bench for phase_unwrap_tracker (default widths plus
// a WIND_W=3 instance for saturation).
module tb_phase_unwrap_tracker;

  logic               clk = 1'b0;
  logic               rst;
  logic [13:0]        data, data5;
  logic               valid, clear, valid5, clear5;
  logic [21:0]        d_o;
  logic [7:0]         w_o;
  logic               v_o, up_o, dn_o, s_o;
  logic [16:0]        d5_o;
  logic [2:0]         w5_o;
  logic               v5_o, up5_o, dn5_o, s5_o;
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 n_up;
  int                 n_dn;
  logic signed [31:0] v;

  always #5 clk = ~clk;

  phase_unwrap_tracker #(.DATA_W(14), .WIND_W(8), .JUMP_THR(8192)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .data_o(d_o), .valid_o(v_o), .winding_o(w_o), .wrap_up_o(up_o),
    .wrap_dn_o(dn_o), .sat_o(s_o));

  phase_unwrap_tracker #(.DATA_W(14), .WIND_W(3), .JUMP_THR(8192)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .data_i(data5), .valid_i(valid5), .clear_i(clear5),
    .data_o(d5_o), .valid_o(v5_o), .winding_o(w5_o), .wrap_up_o(up5_o),
    .wrap_dn_o(dn5_o), .sat_o(s5_o));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vi, input logic signed [31:0] d, input logic ci);
    @(negedge clk);
    valid = vi; data = d[13:0]; clear = ci;
    @(posedge clk); #1;
    valid = 1'b0; clear = 1'b0;
  endtask

  task automatic step5(input logic vi, input logic signed [31:0] d, input logic ci);
    @(negedge clk);
    valid5 = vi; data5 = d[13:0]; clear5 = ci;
    @(posedge clk); #1;
    valid5 = 1'b0; clear5 = 1'b0;
  endtask

  task automatic chk_main(input string tag, input logic vv, input logic signed [63:0] dd,
                          input logic signed [63:0] ww, input logic uu, input logic nn, input logic ss);
    chk({tag, ".valid"}, 64'(v_o), 64'(vv));
    chk({tag, ".data"}, 64'($signed(d_o)), dd);
    chk({tag, ".wind"}, 64'($signed(w_o)), ww);
    chk({tag, ".up"}, 64'(up_o), 64'(uu));
    chk({tag, ".dn"}, 64'(dn_o), 64'(nn));
    chk({tag, ".sat"}, 64'(s_o), 64'(ss));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; clear = 1'b0; data = '0;
    valid5 = 1'b0; clear5 = 1'b0; data5 = '0;

    // 1: reset held 3 cycles while valid toggles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = (i % 2 == 0); valid5 = (i % 2 == 0); data = 14'd1234; data5 = 14'd77;
      @(posedge clk); #1;
      chk_main("rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("rst.valid5", 64'(v5_o), 0);
      chk("rst.data5", 64'(d5_o), 0);
    end
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; valid5 = 1'b0;

    // 2: positive wrap
    step(1'b1, 8000, 1'b0);   chk_main("t2a", 1'b1, 8000, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8150, 1'b0);   chk_main("t2b", 1'b1, 8150, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, -8100, 1'b0);  chk_main("t2c", 1'b1, 8284, 1, 1'b1, 1'b0, 1'b0);

    // 3: negative wrap after clear (first sample taken with clear)
    step(1'b1, 0, 1'b1);      chk_main("t3a", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, -8000, 1'b0);  chk_main("t3b", 1'b1, -8000, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8100, 1'b0);   chk_main("t3c", 1'b1, -8284, -1, 1'b0, 1'b1, 1'b0);

    // 4: wrapped ramp, 200 samples from 100 in +200 steps
    n_up = 0; n_dn = 0;
    for (int k = 0; k < 200; k++) begin
      v = 100 + 200 * k;
      step(1'b1, v, (k == 0));
      chk("t4.valid", 64'(v_o), 1);
      chk("t4.data", 64'($signed(d_o)), 64'(v));
      chk("t4.both", 64'(up_o & dn_o), 0);
      if (up_o) n_up++;
      if (dn_o) n_dn++;
    end
    chk("t4.wind", 64'($signed(w_o)), 2);
    chk("t4.nup", 64'(n_up), 2);
    chk("t4.ndn", 64'(n_dn), 0);

    // 6: clear with a sample while winding=2, then gaps hold outputs
    step(1'b1, -5000, 1'b1);  chk_main("t6a", 1'b1, -5000, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1234, 1'b0);   chk_main("t6b", 1'b0, -5000, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, -777, 1'b0);   chk_main("t6c", 1'b0, -5000, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, -4000, 1'b0);  chk_main("t6d", 1'b1, -4000, 0, 1'b0, 1'b0, 1'b0);

    // 5: WIND_W=3 saturation, limit +3
    step5(1'b1, 8000, 1'b0);
    chk("t5.first", 64'($signed(d5_o)), 8000);
    for (int k = 1; k <= 5; k++) begin
      step5(1'b1, -8000, 1'b0);
      chk("t5.up", 64'(up5_o), 1);
      chk("t5.wind", 64'($signed(w5_o)), (k < 3) ? k : 3);
      chk("t5.sat", 64'(s5_o), (k >= 4) ? 1 : 0);
      chk("t5.data", 64'($signed(d5_o)), -8000 + 16384 * ((k < 3) ? k : 3));
      step5(1'b1, 0, 1'b0);
      chk("t5.noup", 64'(up5_o), 0);
      step5(1'b1, 8000, 1'b0);
      chk("t5.nodn", 64'(dn5_o), 0);
    end
    step5(1'b0, 0, 1'b1);
    chk("t5.clr.wind", 64'($signed(w5_o)), 0);
    chk("t5.clr.sat", 64'(s5_o), 0);
    chk("t5.clr.valid", 64'(v5_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
